// File: rtl/affine_host_if.sv
// Bundles the operand, result and core-facing signals of affine_host.
// master is the host side; slave is the environment (operand source, core, result sink).
interface affine_host_if #(
    parameter int N = 8
);
    logic         in_valid_i;
    logic         in_ready_o;
    logic [N-1:0] in_data_i;

    logic         core_n_rst_o;
    logic [N-1:0] core_ext_data_o;
    logic [N-1:0] core_ext_data_i;
    logic [1:0]   core_prog_addr_i;
    logic         core_halt_i;

    logic         out_valid_o;
    logic         out_ready_i;
    logic [N-1:0] out_r1_o;
    logic [N-1:0] out_r2_o;
    logic [3:0]   out_cycles_o;
    logic         out_err_o;

    modport master (
        input  in_valid_i, in_data_i,
        input  core_ext_data_i, core_prog_addr_i, core_halt_i,
        input  out_ready_i,
        output in_ready_o,
        output core_n_rst_o, core_ext_data_o,
        output out_valid_o, out_r1_o, out_r2_o, out_cycles_o, out_err_o
    );

    modport slave (
        output in_valid_i, in_data_i,
        output core_ext_data_i, core_prog_addr_i, core_halt_i,
        output out_ready_i,
        input  in_ready_o,
        input  core_n_rst_o, core_ext_data_o,
        input  out_valid_o, out_r1_o, out_r2_o, out_cycles_o, out_err_o
    );
endinterface

// File: rtl/affine_host.sv
// Host driver for the affine core: resets the core, runs one program pass on an operand,
// then reads acc1 (core running) and acc2 (core held in reset) and returns both.
module affine_host #(
    parameter int N       = 8,
    parameter int RST_CYC = 2,
    parameter int TIMEOUT = 8
) (
    input logic          clk_i,
    input logic          rst_i,
    affine_host_if.master bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HOLD = 3'd1,
        RUN  = 3'd2,
        CAP1 = 3'd3,
        CAP2 = 3'd4,
        OUT  = 3'd5
    } state_t;

    localparam int HCW = $clog2(RST_CYC) + 1;
    localparam int RCW = $clog2(TIMEOUT) + 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(RST_CYC - 1);
    localparam logic [RCW-1:0] RUN_LAST  = RCW'(TIMEOUT - 1);

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   op_q;
    logic [N-1:0]   r1_q;
    logic [N-1:0]   r2_q;
    logic [3:0]     cyc_q;
    logic           err_q;
    logic [HCW-1:0] hold_cnt;
    logic [RCW-1:0] run_cnt;
    logic           run_timeout;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? 4'hF : v + 4'd1;
    endfunction

    // The run budget is tracked separately from the 4-bit reported count so TIMEOUT may exceed 15.
    assign run_timeout = (run_cnt == RUN_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid_i) state_nxt = HOLD;
            HOLD: if (hold_cnt == HOLD_LAST) state_nxt = RUN;
            RUN: begin
                if (bus.core_halt_i) begin
                    state_nxt = CAP1;
                end else if (run_timeout) begin
                    state_nxt = OUT;
                end
            end
            CAP1: state_nxt = CAP2;
            CAP2: state_nxt = OUT;
            OUT:  if (bus.out_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q     <= '0;
            r1_q     <= '0;
            r2_q     <= '0;
            cyc_q    <= '0;
            err_q    <= 1'b0;
            hold_cnt <= '0;
            run_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid_i) begin
                        op_q     <= bus.in_data_i;
                        r1_q     <= '0;
                        r2_q     <= '0;
                        cyc_q    <= '0;
                        err_q    <= 1'b0;
                        hold_cnt <= '0;
                        run_cnt  <= '0;
                    end
                end
                HOLD: hold_cnt <= hold_cnt + 1'b1;
                RUN: begin
                    run_cnt <= run_cnt + 1'b1;
                    cyc_q   <= sat_inc4(cyc_q);
                    // A halt on the final budget cycle still counts as a normal halt.
                    if (bus.core_halt_i) begin
                        err_q <= err_q | (bus.core_prog_addr_i != 2'b11);
                    end else if (run_timeout) begin
                        err_q <= 1'b1;
                        r1_q  <= '0;
                        r2_q  <= '0;
                    end
                end
                CAP1: r1_q <= bus.core_ext_data_i;
                // Core is back in reset here, so its output mux presents acc2.
                CAP2: r2_q <= bus.core_ext_data_i;
                default: ;
            endcase
        end
    end

    assign bus.in_ready_o      = (state == IDLE);
    assign bus.out_valid_o     = (state == OUT);
    assign bus.core_n_rst_o    = (state == RUN) || (state == CAP1);
    assign bus.core_ext_data_o = op_q;
    assign bus.out_r1_o        = r1_q;
    assign bus.out_r2_o        = r2_q;
    assign bus.out_cycles_o    = cyc_q;
    assign bus.out_err_o       = err_q;
endmodule

// File: tb/tb_affine_host.sv
// Bench for affine_host: a behavioural core model plus directed and randomized jobs
// checked against expected results computed from the job description.
module tb_affine_host;
    localparam int N       = 8;
    localparam int RST_CYC = 2;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    affine_host_if #(.N(N)) bus ();

    affine_host #(.N(N), .RST_CYC(RST_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Core model: halts on its halt_at-th cycle out of reset; output muxes acc1/acc2 on n_rst.
    int           m_halt_at = 0;
    logic [1:0]   m_addr    = 2'b11;
    logic [N-1:0] m_acc1    = '0;
    logic [N-1:0] m_acc2    = '0;
    int           m_cnt     = 0;
    logic         m_halt;

    always @(posedge clk) begin
        if (!bus.core_n_rst_o) m_cnt <= 0;
        else                   m_cnt <= m_cnt + 1;
    end

    assign m_halt               = bus.core_n_rst_o && (m_halt_at != 0) && (m_cnt >= m_halt_at - 1);
    assign bus.core_halt_i      = m_halt;
    assign bus.core_prog_addr_i = m_halt ? m_addr : 2'b00;
    assign bus.core_ext_data_i  = bus.core_n_rst_o ? m_acc1 : m_acc2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.in_ready_o !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("idle_ready", 32'(bus.in_ready_o), 32'd1);
    endtask

    task automatic do_job(input logic [N-1:0] op, input int halt_at, input logic [1:0] addr,
                          input logic [N-1:0] a1, input logic [N-1:0] a2, input int stall);
        bit           halts;
        int           exp_cyc, exp_lat, k, low, ext_bad, rdy_bad;
        bit           seen_high, done;
        logic [N-1:0] exp_r1, exp_r2;
        logic         exp_err;

        halts   = (halt_at >= 1) && (halt_at <= TIMEOUT);
        exp_cyc = halts ? halt_at : TIMEOUT;
        if (exp_cyc > 15) exp_cyc = 15;
        exp_err = halts ? (addr != 2'b11) : 1'b1;
        exp_r1  = halts ? a1 : '0;
        exp_r2  = halts ? a2 : '0;
        exp_lat = halts ? RST_CYC + halt_at + 2 : RST_CYC + TIMEOUT;

        bus.out_ready_i = (stall == 0);
        wait_idle();
        m_halt_at = halt_at;
        m_addr    = addr;
        m_acc1    = a1;
        m_acc2    = a2;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = op;
        @(negedge clk);

        k = 0; low = 0; ext_bad = 0; rdy_bad = 0; seen_high = 0; done = 0;
        while (!done && k < 64) begin
            if (bus.out_valid_o === 1'b1) begin
                done = 1;
            end else begin
                if (bus.core_ext_data_o !== op) ext_bad++;
                if (bus.in_ready_o !== 1'b0) rdy_bad++;
                if (!seen_high && bus.core_n_rst_o === 1'b0) low++;
                else seen_high = 1;
                bus.in_valid_i = 1'($urandom_range(0, 1));
                bus.in_data_i  = N'($urandom);
                @(negedge clk);
                k++;
            end
        end
        bus.in_valid_i = (stall != 0);
        check("out_valid_seen", 32'(done), 32'd1);
        check("latency", 32'(k), 32'(exp_lat));
        check("rst_low_cycles", 32'(low), 32'(RST_CYC));
        check("ext_data_const", 32'(ext_bad), 32'd0);
        check("busy_not_ready", 32'(rdy_bad), 32'd0);
        check("r1", 32'(bus.out_r1_o), 32'(exp_r1));
        check("r2", 32'(bus.out_r2_o), 32'(exp_r2));
        check("cycles", 32'(bus.out_cycles_o), 32'(exp_cyc));
        check("err", 32'(bus.out_err_o), 32'(exp_err));

        for (int i = 0; i < stall; i++) begin
            bus.in_data_i = N'($urandom);
            @(negedge clk);
            check("stall_valid", 32'(bus.out_valid_o), 32'd1);
            check("stall_ready", 32'(bus.in_ready_o), 32'd0);
            check("stall_r1", 32'(bus.out_r1_o), 32'(exp_r1));
            check("stall_r2", 32'(bus.out_r2_o), 32'(exp_r2));
            check("stall_err", 32'(bus.out_err_o), 32'(exp_err));
            check("stall_ext", 32'(bus.core_ext_data_o), 32'(op));
        end
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        check("post_out_valid", 32'(bus.out_valid_o), 32'd0);
        check("post_out_ready", 32'(bus.in_ready_o), 32'd1);
    endtask

    initial begin
        int n;
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.out_ready_i = 1'b0;

        // Initial reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
        check("rst_n_rst", 32'(bus.core_n_rst_o), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        check("rst_ext", 32'(bus.core_ext_data_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed: nominal halt, timeout, bad halt address, output stall
        do_job(8'h05, 4, 2'b11, 8'h12, 8'h34, 0);
        do_job(8'h3C, 0, 2'b11, 8'h77, 8'h88, 0);
        do_job(8'h9A, 3, 2'b01, 8'hA1, 8'hB2, 0);
        do_job(8'h61, 5, 2'b11, 8'h5E, 8'hE5, 5);
        do_job(8'h11, 1, 2'b11, 8'h01, 8'h02, 0);
        do_job(8'h22, TIMEOUT, 2'b11, 8'hC3, 8'h3C, 1);

        // Reset pulse in the middle of a run
        wait_idle();
        m_halt_at = 0;
        bus.out_ready_i = 1'b1;
        bus.in_valid_i  = 1'b1;
        bus.in_data_i   = 8'hA5;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        n = 0;
        while (bus.core_n_rst_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_run_reached", 32'(bus.core_n_rst_o), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mr_in_ready", 32'(bus.in_ready_o), 32'd1);
        check("mr_n_rst", 32'(bus.core_n_rst_o), 32'd0);
        check("mr_out_valid", 32'(bus.out_valid_o), 32'd0);
        check("mr_cycles", 32'(bus.out_cycles_o), 32'd0);
        check("mr_err", 32'(bus.out_err_o), 32'd0);
        check("mr_r1r2", {16'd0, bus.out_r1_o, bus.out_r2_o}, 32'd0);
        check("mr_ext", 32'(bus.core_ext_data_o), 32'd0);

        // Back-to-back jobs with extreme operands
        do_job(8'h00, 2, 2'b11, 8'h0F, 8'hF0, 0);
        do_job(8'hFF, 6, 2'b11, 8'hF0, 8'h0F, 0);

        // Randomized jobs
        for (int j = 0; j < 14; j++) begin
            logic [1:0] a;
            a = ($urandom_range(0, 2) != 0) ? 2'b11 : 2'($urandom);
            do_job(N'($urandom), int'($urandom_range(0, TIMEOUT + 1)), a,
                   N'($urandom), N'($urandom), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
